// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath width, fetch FSM states and base opcodes
// used by fetch, control and the sign extender.
package rv_core_pkg;

  localparam int XLEN    = 64;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;

endpackage : rv_core_pkg

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int XLEN = rv_core_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface : instr_fetch_unit_if

// File: rtl/pc_next_calc.sv
// Next-PC adder: sequential step or branch target, plus a misalignment flag.
// Shared with the branch unit, so it stays purely combinational.
module pc_next_calc #(
  parameter int XLEN = rv_core_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_offset_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);
  import rv_core_pkg::*;

  logic [XLEN-1:0] step;

  // Offset is already sign-extended, so a plain modulo add covers both directions.
  assign step         = branch_taken_i ? branch_offset_i : XLEN'(PC_STEP);
  assign next_pc_o    = pc_i + step;
  assign misaligned_o = |next_pc_o[1:0];

endmodule : pc_next_calc

// File: rtl/instr_fetch_unit.sv
// Single-issue fetch stage: owns the PC, fetches one word per request/ack,
// holds it for decode until consumed, then advances or halts on misalignment.
module instr_fetch_unit #(
  parameter int              XLEN     = rv_core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic [XLEN-1:0]     pc_out,
  input  logic                instr_ready,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_offset,
  output logic                fault,
  output logic [XLEN-1:0]     fetch_count
);
  import rv_core_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .next_pc_o       (next_pc),
    .misaligned_o    (next_misaligned)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          count_d = count_q + XLEN'(1);
          state_d = next_misaligned ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Request is gated by rst_n so an in-flight fetch is dropped the moment
  // reset asserts, not at the next edge.
  assign imem.imem_req  = (state_q == FETCH) && rst_n;
  assign imem.imem_addr = pc_q;

  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign pc_out      = pc_q;
  assign fault       = (state_q == HALT);
  assign fetch_count = count_q;

endmodule : instr_fetch_unit
